alu_arbiter: RTL and testbench

- Shares one multi-cycle ALU (32-bit a/b, 3-bit sel, result, done, start via active-high alu_reset) between N_REQ requesters.
- Round-robin grant, operand capture, ALU sequencing; single-cycle ops complete without waiting; mod (sel=3'b111) waits for alu_done.
- Sits between issuing units and the alu instance; the only driver of the ALU inputs.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_arbiter_if.sv | 29 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice: widths, op encodings,
// the sequencing FSM states and the watchdog counter sizing helper.
package alu_pkg;

    localparam int ALU_W = 32;
    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] SEL_MOD = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WAIT_DONE,
        RESP
    } state_t;

    // Bits needed to count up to 'cycles' inclusive.
    function automatic int timeout_cnt_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: request handshake, packed operands
// and the one-hot response pulse with its result and error flag.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int W     = 32
);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*W-1:0]     req_a;
    logic [N_REQ*W-1:0]     req_b;
    logic [N_REQ*SEL_W-1:0] req_sel;
    logic [N_REQ-1:0]       rsp_valid;
    logic [W-1:0]           rsp_result;
    logic                   rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_sel,
        input  req_ready, rsp_valid, rsp_result, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel,
        output req_ready, rsp_valid, rsp_result, rsp_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after last_grant, with
// wrap-around. Returns a one-hot grant and the matching index.
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int cand;
        // NOTE: every output gets a default before the loop, so no path leaves
        // a value unassigned and no latch is inferred.
        grant = '0;
        idx   = '0;
        cand  = 0;
        // Scan farthest-to-nearest so the nearest requester after last_grant wins.
        for (int k = N; k >= 1; k--) begin
            cand = (int'(last_grant) + k) % N;
            if (req[IDX_W'(cand)]) begin
                grant                 = '0;
                grant[IDX_W'(cand)]   = 1'b1;
                idx                   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between N_REQ requesters with round-robin grant.
// Optional WAIT_DONE watchdog enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int W              = ALU_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             CLK,
    input  logic             reset,
    alu_arbiter_if.slave     bus,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [SEL_W-1:0] alu_sel,
    output logic             alu_reset,
    input  logic [W-1:0]     alu_result,
    input  logic             alu_done
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, b_q, result_q;
    logic [SEL_W-1:0]   sel_q;
    logic [IDX_W-1:0]   g_q, last_q, grant_idx;
    logic [N_REQ-1:0]   grant;
    logic               first_q;
    logic               accept, capture, done_ok, timeout;

    logic [W-1:0]       req_a_arr   [N_REQ];
    logic [W-1:0]       req_b_arr   [N_REQ];
    logic [SEL_W-1:0]   req_sel_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_a_arr[i]   = bus.req_a[i*W +: W];
        assign req_b_arr[i]   = bus.req_b[i*W +: W];
        assign req_sel_arr[i] = bus.req_sel[i*SEL_W +: SEL_W];
    end

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req        (bus.req_valid),
        .last_grant (last_q),
        .grant      (grant),
        .idx        (grant_idx)
    );

    // The ALU clears done only while alu_reset is high, so the first WAIT_DONE cycle may see a stale done.
    assign done_ok = (state_q == WAIT_DONE) && !first_q && alu_done;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= (state_q == WAIT_DONE) ? wait_cnt_q + 1'b1 : '0;
            if (capture)      err_q <= 1'b0;
            else if (timeout) err_q <= 1'b1;
        end
    end

    assign timeout     = (state_q == WAIT_DONE) && !done_ok &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.rsp_err = err_q;
`else
    assign timeout     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (sel_q == SEL_MOD) begin
                    state_d = WAIT_DONE;
                end else begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            WAIT_DONE: begin
                if (done_ok) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else if (timeout) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            g_q      <= '0;
            last_q   <= IDX_W'(N_REQ - 1);
            first_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            first_q <= (state_d == WAIT_DONE) && (state_q != WAIT_DONE);
            if (accept) begin
                a_q   <= req_a_arr[grant_idx];
                b_q   <= req_b_arr[grant_idx];
                sel_q <= req_sel_arr[grant_idx];
                g_q   <= grant_idx;
            end
            if (capture)      result_q <= alu_result;
            else if (timeout) result_q <= '0;
            if (state_q == RESP) last_q <= g_q;
        end
    end

    assign bus.req_ready  = (state_q == IDLE && !reset) ? grant : '0;
    assign bus.rsp_valid  = (state_q == RESP) ? (N_REQ'(1) << g_q) : '0;
    assign bus.rsp_result = result_q;

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sel   = sel_q;
    assign alu_reset = (state_q != WAIT_DONE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against a
// timeline model of grants, response cycles and results, with an ALU stub.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int TO = 8;

    logic             CLK = 1'b0;
    logic             reset;
    logic [W-1:0]     alu_a, alu_b, alu_result;
    logic [SEL_W-1:0] alu_sel;
    logic             alu_reset, alu_done;

    always #5 CLK = ~CLK;

    alu_arbiter_if #(.N_REQ(N), .W(W)) bus ();

    alu_arbiter #(.N_REQ(N), .W(W), .TIMEOUT_CYCLES(TO)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_reset  (alu_reset),
        .alu_result (alu_result),
        .alu_done   (alu_done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [SEL_W-1:0] s);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a * b;
            default: return (b == 0) ? '1 : a % b;
        endcase
    endfunction

    // ALU stub: mod result appears after stub_lat cycles of alu_reset low; garbage before.
    int   stub_cnt   = 0;
    int   stub_lat   = 2;
    logic stub_stale = 1'b0;

    always @(posedge CLK) begin
        if (alu_reset) stub_cnt <= 0;
        else           stub_cnt <= stub_cnt + 1;
    end

    always_comb begin
        alu_done   = 1'b0;
        alu_result = ref_op(alu_a, alu_b, alu_sel);
        if (!alu_reset) alu_done = (stub_cnt + 1 >= stub_lat) || (stub_stale && stub_cnt == 0);
        if (alu_sel == SEL_MOD && (alu_reset || stub_cnt + 1 < stub_lat)) alu_result = 32'hDEAD_BEEF;
    end

    // Requesters and the reference timeline
    bit               pend [N];
    logic [W-1:0]     ra [N], rb [N];
    logic [SEL_W-1:0] rs [N];
    int               ops_left [N];
    bit               rnd_mode = 1'b0;
    int               next_lat = 3;
    bit               next_stale = 1'b0;
    int               last_g = N - 1;
    bit               busy = 1'b0;
    int               rsp_cyc, rsp_g, wd_lo, wd_hi;
    logic [W-1:0]     rsp_exp;
    bit               err_exp;
    int               dut_grants [$];

    function automatic bit any_pend();
        for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic new_op(input int i);
        ra[i]   = $urandom;
        rb[i]   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
        rs[i]   = SEL_W'($urandom_range(0, 7));
        pend[i] = 1'b1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]           = pend[i];
            bus.req_a[i*W +: W]        = ra[i];
            bus.req_b[i*W +: W]        = rb[i];
            bus.req_sel[i*SEL_W +: SEL_W] = rs[i];
        end
    endtask

    task automatic accept(input int g);
        int lat;
        busy  = 1'b1;
        rsp_g = g;
        wd_lo = cyc + 2;
        if (rnd_mode) begin
`ifdef ALU_ARB_TIMEOUT_EN
            next_lat = ($urandom_range(0, 5) == 0) ? 100000 : $urandom_range(2, 10);
`else
            next_lat = $urandom_range(2, 6);
`endif
            next_stale = 1'($urandom_range(0, 1));
        end
        if (rs[g] == SEL_MOD) begin
            lat        = next_lat;
            stub_lat   = next_lat;
            stub_stale = next_stale;
`ifdef ALU_ARB_TIMEOUT_EN
            if (lat > TO) begin
                rsp_cyc = cyc + 2 + TO;
                wd_hi   = cyc + 1 + TO;
                rsp_exp = '0;
                err_exp = 1'b1;
            end else
`endif
            begin
                rsp_cyc = cyc + 2 + lat;
                wd_hi   = cyc + 1 + lat;
                rsp_exp = ref_op(ra[g], rb[g], rs[g]);
                err_exp = 1'b0;
            end
        end else begin
            rsp_cyc = cyc + 2;
            wd_hi   = cyc + 1;
            rsp_exp = ref_op(ra[g], rb[g], rs[g]);
            err_exp = 1'b0;
        end
        pend[g] = 1'b0;
        if (rnd_mode) begin
            if ($urandom_range(0, 3) != 0) new_op(g);
        end else if (ops_left[g] > 0) begin
            ops_left[g]--;
            new_op(g);
        end
    endtask

    // One clock: apply requester state after the falling edge, then sample and compare.
    task automatic step();
        logic [N-1:0] exp_ready, exp_rv, seen;
        int g;
        @(negedge CLK);
        drive();
        #1;
        cyc++;
        g = -1;
        if (!busy)
            for (int k = 1; k <= N; k++)
                if (g < 0 && pend[(last_g + k) % N]) g = (last_g + k) % N;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        seen = bus.req_ready;
        check("req_ready", 64'(seen), 64'(exp_ready));
        for (int i = 0; i < N; i++) if (seen[i]) dut_grants.push_back(i);
        check("alu_reset", 64'(alu_reset), 64'(!(busy && cyc >= wd_lo && cyc <= wd_hi)));
        exp_rv = '0;
        if (busy && cyc == rsp_cyc) exp_rv[rsp_g] = 1'b1;
        check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
        if (exp_rv != '0) begin
            check("rsp_result", 64'(bus.rsp_result), 64'(rsp_exp));
            check("rsp_err", 64'(bus.rsp_err), 64'(err_exp));
            last_g = rsp_g;
            busy   = 1'b0;
        end
        if (rnd_mode)
            for (int i = 0; i < N; i++) begin
                if (i != g && pend[i] && $urandom_range(0, 19) == 0) pend[i] = 1'b0;
                else if (i != g && !pend[i] && $urandom_range(0, 3) == 0) new_op(i);
            end
        if (g >= 0) accept(g);
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((busy || any_pend()) && n < budget) begin
            step();
            n++;
        end
        check("drain_in_budget", 64'(busy || any_pend()), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  64'(bus.req_ready),  64'(0));
        check({tag, "_rsp_valid"},  64'(bus.rsp_valid),  64'(0));
        check({tag, "_rsp_result"}, 64'(bus.rsp_result), 64'(0));
        check({tag, "_rsp_err"},    64'(bus.rsp_err),    64'(0));
        check({tag, "_alu_a"},      64'(alu_a),          64'(0));
        check({tag, "_alu_b"},      64'(alu_b),          64'(0));
        check({tag, "_alu_sel"},    64'(alu_sel),        64'(0));
        check({tag, "_alu_reset"},  64'(alu_reset),      64'(1));
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [SEL_W-1:0] s);
        ra[i] = a; rb[i] = b; rs[i] = s; pend[i] = 1'b1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; ra[i] = '0; rb[i] = '0; rs[i] = '0; ops_left[i] = 0;
        end
        reset = 1'b1;
        drive();
        #12;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Contention: requesters 0 and 1 each issue four ops back to back.
        new_op(0); new_op(1);
        ops_left[0] = 3; ops_left[1] = 3;
        next_lat = 3; next_stale = 1'b0;
        run_until_idle(200);
        check("contention_count", 64'(dut_grants.size()), 64'(8));
        for (int k = 0; k < 8 && k < dut_grants.size(); k++)
            check("contention_grant", 64'(dut_grants[k]), 64'(k % 2));

        // Single-cycle add, then mod with a 5-cycle ALU.
        set_op(0, 32'd42, 32'd9, 3'b000);
        run_until_idle(20);
        check("rsp_hold_add", 64'(bus.rsp_result), 64'(51));
        set_op(1, 32'd42, 32'd9, SEL_MOD);
        next_lat = 5;
        run_until_idle(30);
        check("rsp_hold_mod", 64'(bus.rsp_result), 64'(6));

        // Stale done in the first WAIT_DONE cycle must be ignored.
        set_op(0, 32'd1000, 32'd13, SEL_MOD);
        next_lat = 3; next_stale = 1'b1;
        run_until_idle(30);
        next_stale = 1'b0;

        // Reset in the third WAIT_DONE cycle, then re-issue the same op.
        set_op(1, 32'd1000, 32'd7, SEL_MOD);
        next_lat = 50;
        n = 0;
        while (!(busy && cyc == wd_lo + 2) && n < 30) begin
            step();
            n++;
        end
        check("reached_wait_done", 64'(busy && cyc == wd_lo + 2), 64'(1));
        reset = 1'b1;
        set_op(1, 32'd1000, 32'd7, SEL_MOD);
        drive();
        #1;
        check_reset_outputs("midreset");
        busy = 1'b0;
        last_g = N - 1;
        next_lat = 3;
        @(posedge CLK);
        #1;
        check_reset_outputs("midreset_edge");
        reset = 1'b0;
        run_until_idle(30);
        check("reissue_result", 64'(bus.rsp_result), 64'(1000 % 7));

`ifdef ALU_ARB_TIMEOUT_EN
        // Mod op whose ALU never finishes.
        set_op(2, 32'd100, 32'd7, SEL_MOD);
        next_lat = 100000;
        run_until_idle(40);
`endif

        rnd_mode = 1'b1;
        for (int i = 0; i < N; i++) new_op(i);
        repeat (1500) step();
        rnd_mode = 1'b0;
        run_until_idle(300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
